// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues requests to a
// synchronous ROM with 1-cycle read latency, buffers returned words
// (tagged with their PC) in a small FIFO and hands them to decode over
// a valid/ready handshake. A redirect flushes everything and restarts
// fetch at the aligned target.
module fetch_unit #(
    parameter int unsigned               ADDRESS_WIDTH = 32,
    parameter int unsigned               DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0]  RESET_VECTOR  = '0,
    parameter int unsigned               FIFO_DEPTH    = 4,
    parameter int unsigned               INSTR_BYTES   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic [ADDRESS_WIDTH-1:0] instr_pc_plus4
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [ADDRESS_WIDTH-1:0] STEP       = ADDRESS_WIDTH'(INSTR_BYTES);
    localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~(ADDRESS_WIDTH'(INSTR_BYTES - 1));

    logic [ADDRESS_WIDTH-1:0] fetch_pc;
    logic                     inflight;
    logic [ADDRESS_WIDTH-1:0] inflight_pc;

    logic [DATA_WIDTH-1:0]    data_mem [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_mem   [FIFO_DEPTH];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         count;

    logic                     pop;
    logic                     push;
    logic                     fifo_pop;
    logic [CNT_W:0]           committed;

    // Handshake, credit accounting and request generation
    always_comb begin
        instr_valid = (count != '0);
        pop         = instr_valid & instr_ready;
        push        = inflight & ~redirect;
        fifo_pop    = pop & ~redirect;
        // Slots already spoken for, counting this cycle's pop as freed
        committed   = {1'b0, count} + {{CNT_W{1'b0}}, inflight} - {{CNT_W{1'b0}}, pop};
        imem_req    = ~rst & ~redirect & (committed < (CNT_W + 1)'(FIFO_DEPTH));
        imem_addr   = fetch_pc;
    end

    // Head presentation, zeroed while the buffer is empty
    always_comb begin
        instr          = '0;
        instr_pc       = '0;
        instr_pc_plus4 = '0;
        if (instr_valid) begin
            instr          = data_mem[rd_ptr];
            instr_pc       = pc_mem[rd_ptr];
            instr_pc_plus4 = pc_mem[rd_ptr] + STEP;
        end
    end

    // Fetch PC and in-flight tracking; redirect overrides issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_VECTOR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_target & ALIGN_MASK;
            inflight <= 1'b0;
        end else if (imem_req) begin
            fetch_pc    <= fetch_pc + STEP;
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; redirect empties the buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, fifo_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: capture the returning ROM word with its PC tag
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random
// ready/redirect traffic. The reference model tracks the program-order
// PC stream and restart timing, plus a ROM content function.
module tb_fetch_unit;

    localparam logic [31:0] RV_B = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    logic        redirect_b;
    logic [31:0] redirect_target_b;
    logic        imem_req_b;
    logic [31:0] imem_addr_b;
    logic [31:0] imem_rdata_b = '0;
    logic        instr_valid_b;
    logic        instr_ready_b;
    logic [31:0] instr_b;
    logic [31:0] instr_pc_b;
    logic [31:0] instr_pc_plus4_b;

    fetch_unit #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(32'h0),
        .FIFO_DEPTH(4), .INSTR_BYTES(4)
    ) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .instr_pc(instr_pc), .instr_pc_plus4(instr_pc_plus4)
    );

    fetch_unit #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .RESET_VECTOR(RV_B),
        .FIFO_DEPTH(4), .INSTR_BYTES(4)
    ) dut_b (
        .clk(clk), .rst(rst), .redirect(redirect_b), .redirect_target(redirect_target_b),
        .imem_req(imem_req_b), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
        .instr_valid(instr_valid_b), .instr_ready(instr_ready_b), .instr(instr_b),
        .instr_pc(instr_pc_b), .instr_pc_plus4(instr_pc_plus4_b)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   rom = 32'h0050_0093;
            32'h4:   rom = 32'h0010_0113;
            32'h8:   rom = 32'h0020_81B3;
            32'hC:   rom = 32'h0000_0013;
            default: rom = {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
        endcase
    endfunction

    // Synchronous ROMs, one-cycle read latency
    always @(posedge clk) if (imem_req)   imem_rdata   <= rom(imem_addr);
    always @(posedge clk) if (imem_req_b) imem_rdata_b <= rom(imem_addr_b);

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_pc, exp_b, prev_instr, prev_pc, nxt;
    int          age, b_age, req_seen;
    bit          prev_hold;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_restart();
        age       = 1;
        exp_pc    = 32'h0;
        b_age     = 0;
        exp_b     = RV_B;
        prev_hold = 1'b0;
        req_seen  = 0;
    endtask

    // Called at posedge+1: asserts rst between edges, checks the
    // immediate effect, then releases it just after a later edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check_eq("rst_valid",   instr_valid,   0);
        check_eq("rst_req",     imem_req,      0);
        check_eq("rst_valid_b", instr_valid_b, 0);
        check_eq("rst_req_b",   imem_req_b,    0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_restart();
    endtask

    // One cycle: check at negedge with inputs stable, advance the model
    task automatic tick();
        @(negedge clk);
        if (imem_req) req_seen++;
        check_eq("addr_aligned", {30'h0, imem_addr[1:0]}, 0);
        if (redirect) check_eq("req_in_redirect", imem_req, 0);
        if (age == 1 || age == 2) check_eq("valid_after_restart", instr_valid, 0);
        if (age == 1) begin
            check_eq("addr_at_restart", imem_addr, exp_pc);
            if (!redirect) check_eq("req_at_restart", imem_req, 1);
        end
        if (age == 3) check_eq("valid_at_target", instr_valid, 1);
        if (prev_hold) begin
            check_eq("hold_valid", instr_valid, 1);
            check_eq("hold_instr", instr, prev_instr);
            check_eq("hold_pc", instr_pc, prev_pc);
        end
        if (instr_valid) begin
            nxt = exp_pc + 32'd4;
            check_eq("instr_pc", instr_pc, exp_pc);
            check_eq("instr", instr, rom(exp_pc));
            check_eq("pc_plus4", instr_pc_plus4, nxt);
        end else begin
            check_eq("gated_outputs", instr | instr_pc | instr_pc_plus4, 0);
        end
        prev_hold  = instr_valid && !instr_ready && !redirect;
        prev_instr = instr;
        prev_pc    = instr_pc;
        if (redirect) begin
            exp_pc = redirect_target & ~32'h3;
            age    = 1;
        end else begin
            if (instr_valid && instr_ready) exp_pc = exp_pc + 32'd4;
            age = (age > 0 && age < 3) ? age + 1 : 0;
        end

        if (b_age < 2)  check_eq("b_early_valid", instr_valid_b, 0);
        if (b_age == 2) check_eq("b_first_valid", instr_valid_b, 1);
        if (instr_valid_b) begin
            nxt = exp_b + 32'd4;
            check_eq("b_instr_pc", instr_pc_b, exp_b);
            check_eq("b_instr", instr_b, rom(exp_b));
            check_eq("b_pc_plus4", instr_pc_plus4_b, nxt);
            exp_b = nxt;
        end
        if (b_age < 10) b_age++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_target = '0;
        instr_ready = 1'b1;
        redirect_b = 1'b0;
        redirect_target_b = '0;
        instr_ready_b = 1'b1;
        model_restart();
        @(posedge clk);
        #1;

        // Straight-line fetch with decode always ready
        do_reset();
        repeat (8) tick();

        // Backpressure fills the buffer, then drains in order
        do_reset();
        instr_ready = 1'b0;
        repeat (10) tick();
        check_eq("reqs_until_full", req_seen, 4);
        check_eq("req_when_full", imem_req, 0);
        check_eq("valid_when_full", instr_valid, 1);
        instr_ready = 1'b1;
        repeat (8) tick();

        // Redirect with three buffered and one in flight, pop discarded
        do_reset();
        instr_ready = 1'b0;
        repeat (4) tick();
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect = 1'b0;
        repeat (8) tick();

        // Unaligned target
        redirect = 1'b1;
        redirect_target = 32'h103;
        tick();
        redirect = 1'b0;
        repeat (6) tick();

        // Back-to-back redirects, last one wins
        redirect = 1'b1;
        redirect_target = 32'h200;
        tick();
        redirect_target = 32'h300;
        tick();
        redirect = 1'b0;
        repeat (6) tick();

        // Wrap-around past the top of the address space
        redirect = 1'b1;
        redirect_target = 32'hFFFF_FFF4;
        tick();
        redirect = 1'b0;
        repeat (8) tick();

        // Reset mid-stream
        check_eq("pre_reset_valid", instr_valid, 1);
        do_reset();
        repeat (6) tick();

        // Random ready and redirect traffic
        repeat (600) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_target = $urandom;
            if ($urandom_range(0, 3) == 0) redirect_target = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
            tick();
        end
        redirect = 1'b0;
        instr_ready = 1'b1;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
